tick_timer: RTL

- Parametrised successor of the plain free-running 24-bit counter.
- Adds the following over that counter:
  - configurable width
  - clock prescaler
  - up or down counting
  - free-run, auto-reload and one-shot modes
  - synchronous load
  - terminal-count pulse
- Generates the periodic sample tick and the conversion-timeout timing for the SPI temperature-sensor path, and serves as the general-purpose timer for the rest of the design.

---
 rtl/tick_timer_pkg.sv | 13 +
 rtl/tick_timer_if.sv | 26 ++
 rtl/tick_timer_prescaler.sv | 30 +++
 rtl/tick_timer.sv | 87 ++++++++
 4 files changed

// File: rtl/tick_timer_pkg.sv
// Shared types for the tick timer: counting modes and direction encodings.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle of the tick timer; master drives configuration, slave is the timer.
interface tick_timer_if #(
  parameter int WIDTH      = 24,
  parameter int PRESCALE_W = 8
);
  logic                  en;
  logic [1:0]            mode;
  logic                  dir;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  done;

  modport master (
    output en, mode, dir, load, load_value, limit, prescale,
    input  count, tc, done
  );

  modport slave (
    input  en, mode, dir, load, load_value, limit, prescale,
    output count, tc, done
  );
endinterface

// File: rtl/tick_timer_prescaler.sv
// Clock prescaler: emits one step every prescale+1 enabled cycles; a load restarts the period.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_step
);

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic                  w_wrap;

  // >= rather than == so a shrinking prescale never strands the counter above it
  assign w_wrap = (r_pre_cnt >= i_prescale);
  assign o_step = i_en && w_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pre_cnt <= '0;
    end else if (i_clr) begin
      r_pre_cnt <= '0;
    end else if (i_en) begin
      r_pre_cnt <= w_wrap ? '0 : r_pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/tick_timer.sv
// General-purpose tick timer: prescaled up/down counter with free-run, reload and one-shot modes.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int PRESCALE_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  tick_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             w_step;
  logic             w_term;
  logic             w_bounded;
  logic             w_frozen;
  mode_e            w_mode;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (bus.en),
    .i_clr      (bus.load),
    .i_prescale (bus.prescale),
    .o_step     (w_step)
  );

  // reserved encoding 2'b11 falls into the FREE branches below
  assign w_mode   = mode_e'(bus.mode);
  assign w_frozen = (w_mode == MODE_ONESHOT) && r_done;

  always_comb begin
    w_term    = 1'b0;
    w_bounded = (w_mode == MODE_RELOAD) || (w_mode == MODE_ONESHOT);
    if (bus.dir == DIR_DOWN) begin
      w_term = (r_count == '0);
    end else if (w_bounded) begin
      w_term = (r_count >= bus.limit);
    end else begin
      w_term = (r_count == ALL_ONES);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.load) begin
      r_count <= bus.load_value;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (w_step && !w_frozen) begin
        if (!w_term) begin
          r_count <= (bus.dir == DIR_DOWN) ? r_count - WIDTH'(1) : r_count + WIDTH'(1);
        end else begin
          case (w_mode)
            MODE_RELOAD: begin
              r_count <= (bus.dir == DIR_DOWN) ? bus.limit : '0;
              r_tc    <= 1'b1;
            end
            MODE_ONESHOT: begin
              r_done <= 1'b1;
              r_tc   <= 1'b1;
            end
            default: begin
              r_count <= (bus.dir == DIR_DOWN) ? ALL_ONES : '0;
              r_tc    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.done  = r_done;

endmodule
